uart_frame_xcvr: RTL and testbench

Full-duplex UART transceiver with a programmable baud divider, data width, parity mode and stop-bit count. The TX side accepts a multi-byte command word through a valid/ready handshake and serialises it as back-to-back UART characters, most-significant byte first. The RX side synchronises the serial input, detects start bits and samples each bit at mid-bit. It delivers each received character with parity and framing status. The block sits between the command/register layer and the board-level serial pins.

---
 rtl/uart_frame_xcvr.sv | 212 +++++++++++++++++++++
 tb/tb_uart_frame_xcvr.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_xcvr.sv
// Full-duplex UART transceiver. The TX side serialises a BYTES-character
// command word MSB character first, LSB bit first, with no gap between
// characters. The RX side synchronises the line, validates the start bit at
// half a bit time and samples every following bit at its centre.
module uart_frame_xcvr #(
  parameter int CLK_DIV   = 868,
  parameter int DATA_W    = 8,
  parameter int BYTES     = 2,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W*BYTES-1:0] cmd_in,
  input  logic                    cmd_vld,
  output logic                    cmd_rdy,
  output logic                    tx,
  input  logic                    rx,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_vld,
  output logic                    rd_par_err,
  output logic                    rd_frm_err
);

  localparam int CMD_W  = DATA_W * BYTES;
  localparam int BAUD_W = $clog2(CLK_DIV * STOP_BITS);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam int BYTE_W = $clog2(BYTES + 1);

  localparam logic [BAUD_W-1:0] BIT_END   = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] STOP_END  = BAUD_W'(CLK_DIV * STOP_BITS - 1);
  localparam logic [BAUD_W-1:0] HALF_END  = BAUD_W'(CLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);
  localparam logic              HAS_PAR   = (PARITY != 0);

  // Parity bit for a character: even mode is the XOR, odd mode its inverse.
  function automatic logic par_calc(input logic [DATA_W-1:0] d);
    return (PARITY == 2) ? ^d : ~^d;
  endfunction

  // ---------------------------------------------------------------- TX side
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_state_t;

  tx_state_t           tx_state, tx_state_d;
  logic [BAUD_W-1:0]   tx_baud;
  logic [BIT_W-1:0]    tx_bit;
  logic [BYTE_W-1:0]   tx_byte;
  logic [CMD_W-1:0]    cmd_sh;
  logic [DATA_W-1:0]   char_sh;
  logic                tx_par;
  logic                tx_bit_done;
  logic                tx_accept;

  // TX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_d;
  end

  // TX next state, line level and handshake decoded from the current state.
  always_comb begin
    tx_state_d  = tx_state;
    tx_bit_done = 1'b0;
    tx_accept   = 1'b0;
    cmd_rdy     = 1'b0;
    tx          = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_vld) begin
          tx_accept  = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (tx_baud == BIT_END) begin
          tx_bit_done = 1'b1;
          tx_state_d  = TX_DATA;
        end
      end
      TX_DATA: begin
        tx = char_sh[0];
        if (tx_baud == BIT_END) begin
          tx_bit_done = 1'b1;
          if (tx_bit == BIT_LAST) tx_state_d = HAS_PAR ? TX_PAR : TX_STOP;
        end
      end
      TX_PAR: begin
        tx = tx_par;
        if (tx_baud == BIT_END) begin
          tx_bit_done = 1'b1;
          tx_state_d  = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_baud == STOP_END) begin
          tx_bit_done = 1'b1;
          tx_state_d  = (tx_byte == BYTE_LAST) ? TX_IDLE : TX_START;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX baud, bit and character counters; baud restarts at every bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_baud <= '0;
      tx_bit  <= '0;
      tx_byte <= '0;
    end else begin
      if (tx_state == TX_IDLE || tx_bit_done) tx_baud <= '0;
      else                                    tx_baud <= tx_baud + BAUD_W'(1);
      if (tx_state == TX_START && tx_bit_done)     tx_bit <= '0;
      else if (tx_state == TX_DATA && tx_bit_done) tx_bit <= tx_bit + BIT_W'(1);
      if (tx_accept)                               tx_byte <= '0;
      else if (tx_state == TX_STOP && tx_bit_done) tx_byte <= tx_byte + BYTE_W'(1);
    end
  end

  // TX data path: command capture, per-character load at the end of START, LSB-first shift.
  always_ff @(posedge clk) begin
    if (tx_accept) begin
      cmd_sh <= cmd_in;
    end else if (tx_state == TX_START && tx_bit_done) begin
      char_sh <= cmd_sh[CMD_W-1 -: DATA_W];
      tx_par  <= par_calc(cmd_sh[CMD_W-1 -: DATA_W]);
      cmd_sh  <= cmd_sh << DATA_W;
    end else if (tx_state == TX_DATA && tx_bit_done) begin
      char_sh <= char_sh >> 1;
    end
  end

  // ---------------------------------------------------------------- RX side
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t           rx_state, rx_state_d;
  logic                rx_p0, rx_p1;
  logic [BAUD_W-1:0]   rx_baud;
  logic [BIT_W-1:0]    rx_bit;
  logic [DATA_W-1:0]   rx_sh;
  logic                rx_par;
  logic                rx_tick;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_d;
  end

  // RX next state: half-bit start check, then one sample per full bit time.
  always_comb begin
    rx_state_d = rx_state;
    rx_tick    = (rx_state == RX_START) ? (rx_baud == HALF_END) : (rx_baud == BIT_END);
    case (rx_state)
      RX_IDLE:      if (!rx_p1) rx_state_d = RX_START;
      RX_START:     if (rx_tick) rx_state_d = rx_p1 ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_tick && rx_bit == BIT_LAST) rx_state_d = HAS_PAR ? RX_PAR : RX_STOP;
      RX_PAR:       if (rx_tick) rx_state_d = RX_STOP;
      RX_STOP:      if (rx_tick) rx_state_d = rx_p1 ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_p1) rx_state_d = RX_IDLE;
      default:      rx_state_d = RX_IDLE;
    endcase
  end

  // RX counters and the delivered character with its status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_baud    <= '0;
      rx_bit     <= '0;
      rd_vld     <= 1'b0;
      rd_data    <= '0;
      rd_par_err <= 1'b0;
      rd_frm_err <= 1'b0;
    end else begin
      if (rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH || rx_tick) rx_baud <= '0;
      else                                                          rx_baud <= rx_baud + BAUD_W'(1);
      if (rx_state == RX_START)                rx_bit <= '0;
      else if (rx_state == RX_DATA && rx_tick) rx_bit <= rx_bit + BIT_W'(1);
      rd_vld <= (rx_state == RX_STOP) && rx_tick;
      if (rx_state == RX_STOP && rx_tick) begin
        rd_data    <= rx_sh;
        rd_par_err <= HAS_PAR && (rx_par != par_calc(rx_sh));
        rd_frm_err <= !rx_p1;
      end
    end
  end

  // RX data path: LSB-first shift of data bits and capture of the parity bit.
  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_tick) rx_sh  <= {rx_p1, rx_sh[DATA_W-1:1]};
    if (rx_state == RX_PAR && rx_tick)  rx_par <= rx_p1;
  end

endmodule

// File: tb/tb_uart_frame_xcvr.sv
// Directed bench for uart_frame_xcvr: one odd-parity instance driven from the
// bench and one even-parity, two-stop-bit instance with tx looped to rx.
module tb_uart_frame_xcvr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd_in, cmd_in_e;
  logic        cmd_vld, cmd_vld_e;
  logic        cmd_rdy, cmd_rdy_e;
  logic        tx, tx_e;
  logic        rx_drv;
  logic [7:0]  rd_data, rd_data_e;
  logic        rd_vld, rd_vld_e;
  logic        rd_par_err, rd_par_err_e;
  logic        rd_frm_err, rd_frm_err_e;

  int vectors = 0;
  int miscompares = 0;

  int         n_vld = 0;
  logic [7:0] cap_data;
  logic       cap_par, cap_frm;
  int         n_vld_e = 0;
  logic [7:0] cap_e_data[4];
  logic       cap_e_par[4];
  logic       cap_e_frm[4];

  uart_frame_xcvr #(.CLK_DIV(4), .DATA_W(8), .BYTES(2), .PARITY(1), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .tx(tx), .rx(rx_drv), .rd_data(rd_data), .rd_vld(rd_vld),
    .rd_par_err(rd_par_err), .rd_frm_err(rd_frm_err)
  );

  uart_frame_xcvr #(.CLK_DIV(4), .DATA_W(8), .BYTES(2), .PARITY(2), .STOP_BITS(2)) dut_e (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in_e), .cmd_vld(cmd_vld_e), .cmd_rdy(cmd_rdy_e),
    .tx(tx_e), .rx(tx_e), .rd_data(rd_data_e), .rd_vld(rd_vld_e),
    .rd_par_err(rd_par_err_e), .rd_frm_err(rd_frm_err_e)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance to the next falling edge and record any rd_vld pulse seen there.
  task automatic tick();
    @(negedge clk);
    if (rd_vld) begin
      n_vld++;
      cap_data = rd_data;
      cap_par  = rd_par_err;
      cap_frm  = rd_frm_err;
    end
    if (rd_vld_e) begin
      if (n_vld_e < 4) begin
        cap_e_data[n_vld_e] = rd_data_e;
        cap_e_par[n_vld_e]  = rd_par_err_e;
        cap_e_frm[n_vld_e]  = rd_frm_err_e;
      end
      n_vld_e++;
    end
  endtask

  // Expected line level for bit slot b of a 2-char, 8N-odd-1 command.
  function automatic logic fbit(input logic [15:0] cmd, input int b);
    int         ch;
    int         pos;
    logic [7:0] by;
    logic [7:0] t;
    ch  = b / 11;
    pos = b % 11;
    by  = (ch == 0) ? cmd[15:8] : cmd[7:0];
    if (pos == 0) return 1'b0;
    if (pos == 9) return ~^by;
    if (pos == 10) return 1'b1;
    t = by >> (pos - 1);
    return t[0];
  endfunction

  // Send 16'hA53C and check every cycle against the hand-written bit stream.
  task automatic send_hand(input string pfx);
    logic [21:0] exp_tx;
    logic [21:0] sh;
    exp_tx = 22'b01010010111_00011110011;
    cmd_in  = 16'hA53C;
    cmd_vld = 1'b1;
    tick();
    cmd_vld = 1'b0;
    for (int c = 0; c <= 88; c++) begin
      sh = exp_tx << (c / 4);
      chk($sformatf("%s_tx_c%0d", pfx, c), tx, (c < 88) ? sh[21] : 1'b1);
      chk($sformatf("%s_rdy_c%0d", pfx, c), cmd_rdy, (c >= 88) ? 1'b1 : 1'b0);
      if (c < 88) tick();
    end
  endtask

  // Drive one 11-bit frame on dut's rx, 4 clocks per bit.
  task automatic drive_rx(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] fr;
    fr = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_drv = fr[i];
      repeat (4) tick();
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int          base;
    logic [15:0] f;
    logic [15:0] cmd1, cmd2;
    logic        e;

    rst_n = 1'b0; cmd_in = '0; cmd_vld = 1'b0; rx_drv = 1'b1;
    cmd_in_e = '0; cmd_vld_e = 1'b0;
    cmd1 = '0; cmd2 = '0;
    repeat (3) tick();
    chk("rst_tx", tx, 1'b1);
    chk("rst_rdy", cmd_rdy, 1'b1);
    chk("rst_vld", rd_vld, 1'b0);
    chk("rst_data", rd_data, 8'h00);
    chk("rst_par", rd_par_err, 1'b0);
    chk("rst_frm", rd_frm_err, 1'b0);
    chk("rst_tx_e", tx_e, 1'b1);
    chk("rst_rdy_e", cmd_rdy_e, 1'b1);
    rst_n = 1'b1;
    repeat (2) tick();

    // Two-character odd-parity command, exact bit stream and cmd_rdy timing.
    send_hand("t1");
    chk("t1_no_rx", n_vld, 0);

    // Even parity, two stop bits, looped back.
    cmd_in_e  = 16'h00FF;
    cmd_vld_e = 1'b1;
    tick();
    cmd_vld_e = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (c == 0)  chk("t2_rdy_lo0", cmd_rdy_e, 1'b0);
      if (c == 95) chk("t2_rdy_lo95", cmd_rdy_e, 1'b0);
      if (c == 96) chk("t2_rdy_hi96", cmd_rdy_e, 1'b1);
      tick();
    end
    chk("t2_count", n_vld_e, 2);
    chk("t2_data0", cap_e_data[0], 8'h00);
    chk("t2_data1", cap_e_data[1], 8'hFF);
    chk("t2_par0", cap_e_par[0], 1'b0);
    chk("t2_par1", cap_e_par[1], 1'b0);
    chk("t2_frm0", cap_e_frm[0], 1'b0);
    chk("t2_frm1", cap_e_frm[1], 1'b0);

    // 0x55 with a wrong odd-parity bit (correct would be 1).
    base = n_vld;
    drive_rx(8'h55, 1'b0, 1'b1);
    repeat (12) tick();
    chk("t3_count", n_vld - base, 1);
    chk("t3_data", cap_data, 8'h55);
    chk("t3_par", cap_par, 1'b1);
    chk("t3_frm", cap_frm, 1'b0);
    chk("t3_hold", rd_data, 8'h55);

    // One-cycle glitch: false start.
    base = n_vld;
    rx_drv = 1'b0;
    tick();
    rx_drv = 1'b1;
    repeat (50) tick();
    chk("t4_glitch", n_vld - base, 0);

    // Break of 20 bit times: one character of zeros, framing error, odd parity error.
    base = n_vld;
    rx_drv = 1'b0;
    repeat (80) tick();
    rx_drv = 1'b1;
    repeat (8) tick();
    chk("t4_brk_count", n_vld - base, 1);
    chk("t4_brk_data", cap_data, 8'h00);
    chk("t4_brk_frm", cap_frm, 1'b1);
    chk("t4_brk_par", cap_par, 1'b1);

    base = n_vld;
    drive_rx(8'h81, 1'b1, 1'b1);
    repeat (12) tick();
    chk("t4_nxt_count", n_vld - base, 1);
    chk("t4_nxt_data", cap_data, 8'h81);
    chk("t4_nxt_par", cap_par, 1'b0);
    chk("t4_nxt_frm", cap_frm, 1'b0);

    // cmd_vld held high with a new cmd_in every cycle: only cycles 0 and 89 are taken.
    for (int d = 0; d < 178; d++) begin
      f = 16'h5A00 ^ (16'(d) * 16'h1357);
      if (d == 0)  cmd1 = f;
      if (d == 89) cmd2 = f;
      cmd_in  = f;
      cmd_vld = 1'b1;
      tick();
      if (d < 88)       e = fbit(cmd1, d / 4);
      else if (d == 88) e = 1'b1;
      else if (d < 177) e = fbit(cmd2, (d - 89) / 4);
      else              e = 1'b1;
      chk($sformatf("t5_tx_c%0d", d), tx, e);
      chk($sformatf("t5_rdy_c%0d", d), cmd_rdy, (d == 88 || d == 177) ? 1'b1 : 1'b0);
    end
    cmd_vld = 1'b0;
    repeat (4) tick();

    // Asynchronous reset in the middle of a TX data bit and an RX frame.
    base = n_vld;
    cmd_in  = 16'h0000;
    cmd_vld = 1'b1;
    rx_drv  = 1'b0;
    tick();
    cmd_vld = 1'b0;
    repeat (9) tick();
    chk("t6_pre_tx", tx, 1'b0);
    chk("t6_pre_rdy", cmd_rdy, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_tx", tx, 1'b1);
    chk("t6_rst_rdy", cmd_rdy, 1'b1);
    chk("t6_rst_vld", rd_vld, 1'b0);
    chk("t6_rst_data", rd_data, 8'h00);
    rx_drv = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t6_post_tx", tx, 1'b1);
    chk("t6_post_rdy", cmd_rdy, 1'b1);
    chk("t6_post_novld", n_vld - base, 0);
    send_hand("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
